sensor_adc_scanner: RTL
=======================

// Module: sensor_adc_scanner
// PURPOSE
//  Multi-channel successor to the per-sensor ADC front ends (soil, DHT11, rain).
//  - Scans NUM_CH millivolt inputs round-robin; per channel: settle, average 2^AVG_LOG2 samples, emit one code.
//  - Codes go out on a valid/ready stream and into a per-channel holding register bank.
//  - Exact scaling replaces the integer-step approximation. Sits between the sensor inputs and the controller.
// PARAMETERS
//  NUM_CH        3     number of channels (1..16)
//  RESOLUTION    10    output code width in bits
//  VREF_MV       5000  full-scale reference in mV
//  AVG_LOG2      2     log2 of samples averaged per channel (0..4)
//  SETTLE_CYCLES 4     cycles idled after selecting a channel (>=1)
// PORTS
//  clk            in   1                  rising-edge clock
//  reset          in   1                  asynchronous, active-high reset
//  analog_mv      in   16*NUM_CH          packed mV inputs; ch k = [16k+15:16k]
//  scan_enable    in   1                  continuous mode: keep rescanning while high
//  scan_start     in   1                  single-scan request pulse (used when scan_enable=0)
//  out_valid      out  1                  stream word valid
//  out_ready      in   1                  downstream accepts word
//  out_ch         out  $clog2(NUM_CH)>=1  channel of current word
//  out_code       out  RESOLUTION         averaged code
//  digital_out    out  RESOLUTION*NUM_CH  last accepted code per channel (packed as analog_mv)
//  scan_done      out  1                  1-cycle pulse after last channel's word is accepted
//  busy           out  1                  high in any state but IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, ch=0, acc=0, counters=0.
//   Outputs: out_valid=0, out_ch=0, out_code=0, digital_out=0, scan_done=0, busy=0.
//  Conversion, per sample: code = (mv >= VREF_MV) ? 2^RES-1 : (mv * 2^RES) / VREF_MV.
//   Product is 16+RESOLUTION bits wide; quotient truncates.
//  Averaging: acc is RESOLUTION+AVG_LOG2 bits, cleared on entry to SAMPLE.
//   out_code = acc >> AVG_LOG2 (truncate). AVG_LOG2=0 means one sample.
//  FSM:
//   IDLE:   go to SETTLE when scan_enable=1 or scan_start=1; ch=0.
//   SETTLE: hold SETTLE_CYCLES cycles, then SAMPLE.
//   SAMPLE: one conversion of analog_mv[ch] per cycle for 2^AVG_LOG2 cycles, then EMIT.
//    The input is sampled live each cycle; no input latching.
//   EMIT:   out_valid=1; out_ch and out_code are stable until handshake (out_valid & out_ready).
//    On handshake: digital_out[ch] <= out_code and out_valid drops next cycle.
//    If ch < NUM_CH-1: ch++ and go to SETTLE.
//    If ch = NUM_CH-1: ch wraps to 0, scan_done pulses next cycle, and the next state is
//    SETTLE if scan_enable=1, else IDLE.
//  Latency: scan_start sampled at edge E gives first out_valid at E+1+SETTLE_CYCLES+2^AVG_LOG2
//   (ready held high). Back-pressure stalls only EMIT; nothing is dropped.
//  scan_enable falling mid-scan: the current scan completes all channels, then IDLE.
//  scan_start while busy: ignored. scan_start with scan_enable=1: same as continuous mode.
//  out_ready high outside EMIT: no effect. digital_out changes only on a handshake.
//  Reset mid-operation: immediate return to reset values; a partial accumulation is discarded.
// STRUCTURE
//  sensor_adc_pkg: state enum {IDLE,SETTLE,SAMPLE,EMIT}; CH_W=max(1,$clog2(NUM_CH)) helper;
//   MAX_CODE constant.
//  Sub-module adc_code_conv (combinational: mv in, saturated code out), one instance on the
//   muxed channel. FSM, counters, accumulator and register bank live in the top.
// TESTING (defaults: NUM_CH=3, RES=10, VREF=5000, AVG_LOG2=2, SETTLE=4)
//  1 Single scan, ready=1, inputs {ch0=2500, ch1=1000, ch2=0}:
//    words (0,512), (1,204), (2,0); scan_done once; busy falls; first valid 9 cycles after start.
//  2 Saturation: ch0=5000, ch1=6000, ch2=4999 -> codes 1023, 1023, 1023.
//  3 Averaging: ch0 toggles 1000/3000 per cycle during SAMPLE -> code 409 ((204+614+204+614)/4);
//    digital_out[0]=409.
//  4 Back-pressure: ready=0 for 20 cycles in EMIT -> valid held, ch/code stable, no advance;
//    ready=1 -> one handshake only.
//  5 Continuous: scan_enable=1 for 2.5 scans, then 0 -> scans 1-3 complete fully, 3 scan_done
//    pulses, then IDLE.
//  6 Reset asserted in SAMPLE of ch1 -> all outputs 0 at once; next start begins at ch0 with a
//    fresh accumulation.

Source files
------------

// File: rtl/sensor_adc_pkg.sv
// Shared types and sizing helpers for the multi-channel sensor ADC scanner.
package sensor_adc_pkg;

  localparam int MV_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    EMIT
  } state_e;

  // Channel index width; a single-channel build still needs a 1-bit out_ch.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/adc_code_conv.sv
// Combinational millivolt-to-code converter with saturation at the reference voltage.
module adc_code_conv
  import sensor_adc_pkg::*;
#(
  parameter int RESOLUTION = 10,
  parameter int VREF_MV    = 5000
) (
  input  logic [MV_W-1:0]       mv,
  output logic [RESOLUTION-1:0] code
);

  localparam int                PW       = MV_W + RESOLUTION;
  localparam logic [PW-1:0]     VREF     = PW'(VREF_MV);
  localparam logic [RESOLUTION-1:0] MAX_CODE = '1;

  logic [PW-1:0] prod;

  // Below VREF the quotient is < 2^RESOLUTION, so the narrowing cast only drops zeros.
  always_comb begin
    prod = {mv, {RESOLUTION{1'b0}}};
    code = (PW'(mv) >= VREF) ? MAX_CODE : RESOLUTION'(prod / VREF);
  end

endmodule

// File: rtl/sensor_adc_scanner.sv
// Round-robin scanner: settle, average 2^AVG_LOG2 conversions, emit one code per channel
// on a valid/ready stream and record accepted codes in a per-channel register bank.
module sensor_adc_scanner
  import sensor_adc_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int RESOLUTION    = 10,
  parameter int VREF_MV       = 5000,
  parameter int AVG_LOG2      = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [MV_W*NUM_CH-1:0]       analog_mv,
  input  logic                         scan_enable,
  input  logic                         scan_start,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ch_width(NUM_CH)-1:0]  out_ch,
  output logic [RESOLUTION-1:0]        out_code,
  output logic [RESOLUTION*NUM_CH-1:0] digital_out,
  output logic                         scan_done,
  output logic                         busy
);

  localparam int CH_W    = ch_width(NUM_CH);
  localparam int ACC_W   = RESOLUTION + AVG_LOG2;
  localparam int N_SAMP  = 1 << AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_CYCLES > N_SAMP) ? SETTLE_CYCLES : N_SAMP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                       state_q, state_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [ACC_W-1:0]             acc_q, acc_d;
  logic [RESOLUTION-1:0]        out_code_q, out_code_d;
  logic [RESOLUTION*NUM_CH-1:0] bank_q, bank_d;
  logic                         done_q, done_d;

  logic [MV_W-1:0]       mv_sel;
  logic [RESOLUTION-1:0] conv_code;

  always_comb begin
    mv_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) mv_sel = analog_mv[MV_W*k +: MV_W];
    end
  end

  adc_code_conv #(
    .RESOLUTION (RESOLUTION),
    .VREF_MV    (VREF_MV)
  ) u_conv (
    .mv   (mv_sel),
    .code (conv_code)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_code_d = out_code_q;
    bank_d     = bank_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        ch_d  = '0;
        cnt_d = '0;
        if (scan_enable || scan_start) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        // N_SAMP accumulation cycles, then one cycle to register the average.
        if (cnt_q == CNT_W'(N_SAMP)) begin
          out_code_d = RESOLUTION'(acc_q >> AVG_LOG2);
          state_d    = EMIT;
          cnt_d      = '0;
        end else begin
          acc_d = acc_q + ACC_W'(conv_code);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) bank_d[RESOLUTION*k +: RESOLUTION] = out_code_q;
          end
          cnt_d = '0;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            ch_d    = '0;
            done_d  = 1'b1;
            state_d = scan_enable ? SETTLE : IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_code_q <= '0;
      bank_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_code_q <= out_code_d;
      bank_q     <= bank_d;
      done_q     <= done_d;
    end
  end

  assign out_valid   = (state_q == EMIT);
  assign out_ch      = ch_q;
  assign out_code    = out_code_q;
  assign digital_out = bank_q;
  assign scan_done   = done_q;
  assign busy        = (state_q != IDLE);

endmodule
